// File: rtl/mux_rr_arbiter_if.sv
// Handshake and select bundle between the round-robin arbiter and its requesters/consumer.
// Burst-lock signals exist only when ARB_BURST_LOCK_EN is defined.
interface mux_rr_arbiter_if;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] mux_sel;
    logic       busy;
`ifdef ARB_BURST_LOCK_EN
    logic [3:0] req_last;
    logic       out_last;

    modport master (
        input  req_valid, out_ready, req_last,
        output req_ready, out_valid, mux_sel, busy, out_last
    );

    modport slave (
        output req_valid, out_ready, req_last,
        input  req_ready, out_valid, mux_sel, busy, out_last
    );
`else
    modport master (
        input  req_valid, out_ready,
        output req_ready, out_valid, mux_sel, busy
    );

    modport slave (
        output req_valid, out_ready,
        input  req_ready, out_valid, mux_sel, busy
    );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-to-1 mux; payload flows outside on mux_sel.
// Optional burst lock (req_last/out_last, MAX_BURST cap) is enabled by ARB_BURST_LOCK_EN.
module mux_rr_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("mux_rr_arbiter: MAX_BURST must be in 1..255");
    end

    state_e     state_q, state_d;
    logic [1:0] mux_sel_q, mux_sel_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] winner;
    logic       any_req;
    logic       sel_valid;
    logic       xfer;
    logic [3:0] req_ready;
    logic       out_valid;
    logic       busy;
`ifdef ARB_BURST_LOCK_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       out_last;
`endif

    // Scanning from the lowest priority slot down to the highest lets the last hit win,
    // which avoids a separate found flag.
    always_comb begin
        winner  = rr_ptr_q;
        any_req = |bus.req_valid;
        for (int i = 4; i >= 1; i--) begin
            if (bus.req_valid[2'(rr_ptr_q + 2'(i))]) begin
                winner = 2'(rr_ptr_q + 2'(i));
            end
        end
    end

    assign sel_valid = bus.req_valid[mux_sel_q];
    assign xfer      = (state_q == GRANT) && sel_valid && bus.out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        mux_sel_d  = mux_sel_q;
        rr_ptr_d   = rr_ptr_q;
        req_ready  = 4'b0000;
        out_valid  = 1'b0;
        busy       = 1'b0;
`ifdef ARB_BURST_LOCK_EN
        beat_cnt_d = beat_cnt_q;
        out_last   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = GRANT;
                    mux_sel_d  = winner;
                    rr_ptr_d   = winner;
`ifdef ARB_BURST_LOCK_EN
                    beat_cnt_d = 8'd0;
`endif
                end
            end
            GRANT: begin
                busy                 = 1'b1;
                out_valid            = sel_valid;
                req_ready[mux_sel_q] = bus.out_ready;
`ifdef ARB_BURST_LOCK_EN
                out_last             = bus.req_last[mux_sel_q];
`endif
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (xfer) begin
`ifdef ARB_BURST_LOCK_EN
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Force release once MAX_BURST beats have moved without a last flag.
                    if (bus.req_last[mux_sel_q] || (beat_cnt_q == 8'(MAX_BURST - 1))) begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: synchronous reset with non-blocking updates; rst beats every other event,
    // so a grant in flight is dropped at the edge where rst is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mux_sel_q  <= 2'b00;
            rr_ptr_q   <= 2'd3;
`ifdef ARB_BURST_LOCK_EN
            beat_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            mux_sel_q  <= mux_sel_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef ARB_BURST_LOCK_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.busy      = busy;
`ifdef ARB_BURST_LOCK_EN
    assign bus.out_last  = out_last;
`endif

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-to-1 data_t multiplexer.
- Four requesters compete for one downstream valid/ready channel. The block drives the mux select and routes the handshake between the winning requester and the downstream consumer.
- Payload never passes through this block; it flows through the external mux on `mux_sel`.

Parameters:
- MAX_BURST, 16, maximum beats per grant when burst lock is compiled in. Legal range 1..255. Unused otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester valid; bit i = requester i.
- req_ready  output  4  per-requester ready; at most one bit high.
- out_valid  output  1  downstream valid.
- out_ready  input  1  downstream ready.
- mux_sel  output  2  select to the 4-to-1 mux; registered.
- busy  output  1  high while in GRANT state.
- req_last  input  4  per-requester last-beat flag (only with ARB_BURST_LOCK_EN).
- out_last  output  1  equals req_last[mux_sel] in GRANT (only with ARB_BURST_LOCK_EN).

Behaviour:
- Reset values: state=IDLE, mux_sel=2'b00, rr_ptr=2'd3 (requester 0 has first priority after reset), req_ready=4'b0, out_valid=0, busy=0, out_last=0, beat counter=0.
- rst has priority over every other event. A reset asserted mid-grant aborts the grant at the next edge; no transfer completes in that cycle.
- States are IDLE and GRANT; the state is registered.
- IDLE:
  - req_ready=0, out_valid=0.
  - If any req_valid bit is set, pick the winner by searching from (rr_ptr+1) mod 4 upward with wrap-around. The first set bit wins.
  - Next edge: mux_sel<=winner, rr_ptr<=winner, state<=GRANT.
  - If no request, stay in IDLE; mux_sel holds its previous value.
- GRANT, combinational outputs:
  - out_valid = req_valid[mux_sel].
  - req_ready[mux_sel] = out_ready; all other req_ready bits are 0.
  - busy=1.
- Transfer: a beat transfers on any edge where req_valid[mux_sel] and out_ready are both high.
- GRANT, single-beat mode (no macro): after one transfer, state<=IDLE.
- Abort: if req_valid[mux_sel] is low in GRANT, state<=IDLE at the next edge with no transfer. rr_ptr keeps the aborted winner, so it loses priority.
- Arbitration latency: one idle bubble cycle per grant. Request seen in IDLE at cycle N → GRANT at N+1 → earliest transfer at the end of N+1. Peak throughput is 1 beat per 2 cycles.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,... A requester waits at most 3 grants.
- Requesters changing req_valid bits during GRANT do not affect mux_sel until the next IDLE evaluation.
- Downstream back-pressure (out_ready=0) holds GRANT indefinitely. mux_sel is stable for the whole grant.

Optional Feature:
- Macro: ARB_BURST_LOCK_EN.
- Defined:
  - req_last and out_last ports exist.
  - GRANT stays locked to mux_sel until a beat with req_last[mux_sel]=1 transfers, then state<=IDLE.
  - An 8-bit beat counter clears on entry to GRANT and increments per transfer.
  - When the counter reaches MAX_BURST transfers without last, the grant is force-released to IDLE after that beat.
  - The abort rule (valid low in GRANT) still applies.
- Undefined: ports absent, single-beat grants, counter not implemented.

Test Plan:
- Reset: hold rst for 3 cycles with req_valid=4'b1111 → req_ready=0, out_valid=0, busy=0, mux_sel=0. First grant after release goes to requester 0.
- Rotation: req_valid=4'b1111 and out_ready=1 constantly for 16 cycles → mux_sel sequence 0,1,2,3,0,1,2,3 in GRANT cycles, one transfer every 2 cycles, 8 transfers total.
- Skip and wrap: rr_ptr=2 after granting requester 2, then req_valid=4'b0011 → next grant is requester 0 (wrap past 3), then 1.
- Back-pressure: requester 1 alone, out_ready=0 for 5 cycles then 1 → busy=1 and mux_sel=1 held for 5 cycles, req_ready=4'b0000 throughout, exactly one transfer on cycle 6, then IDLE.
- Abort: requester 2 granted, req_valid[2] dropped before out_ready → IDLE next cycle with zero transfers. A pending requester 3 wins next.
- Burst (ARB_BURST_LOCK_EN, MAX_BURST=4):
  - Requester 0 sends a 3-beat burst (last on beat 3) while requester 1 requests → mux_sel=0 for all 3 beats, then grant to 1.
  - A 6-beat burst without last → release after beat 4.
